// File: rtl/sram_arbiter.sv
// N-channel request arbiter and wait-state timing engine for one asynchronous SRAM chip.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority.
//
// state  | meaning
// IDLE   | waiting for any req; winner latched on the leaving edge
// SETUP  | addr/en asserted (oe for read, data driven for write); one cycle
// ACCESS | strobe active (oe or we) for WAIT_CYCLES cycles
// DONE   | strobes released, done[grant_id] pulses for one cycle
module sram_arbiter #(
    parameter int NUM_CH      = 3,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH-1:0]          wr,
    input  logic [NUM_CH*ADDR_W-1:0]   addr,
    input  logic [NUM_CH*DATA_W-1:0]   wdata,
    output logic [NUM_CH-1:0]          done,
    output logic [DATA_W-1:0]          rdata,
    output logic                       busy,
    output logic [$clog2(NUM_CH)-1:0]  grant_id,
    output logic [ADDR_W-1:0]          sram_addr,
    inout  wire  [DATA_W-1:0]          sram_data,
    output logic                       sram_en,
    output logic                       sram_oe,
    output logic                       sram_we
);

    localparam int GRANT_W = $clog2(NUM_CH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t              state;
    logic                op_wr;
    logic                drive;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          wait_cnt;
    logic [GRANT_W-1:0]  winner;

    // The bus is only ever driven from a register, so release happens exactly on a clock or reset edge.
    assign sram_data = drive ? wdata_q : {DATA_W{1'bz}};

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [GRANT_W-1:0] last_grant;

    // Walk the offsets from farthest to nearest so the channel just after last_grant wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (req[idx]) begin
                winner = GRANT_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_W'(NUM_CH - 1);
        end else if (state == IDLE && |req) begin
            last_grant <= winner;
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = GRANT_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            done      <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            sram_addr <= '0;
            sram_en   <= 1'b1;
            sram_oe   <= 1'b1;
            sram_we   <= 1'b1;
            drive     <= 1'b0;
            op_wr     <= 1'b0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id  <= winner;
                        op_wr     <= wr[winner];
                        sram_addr <= addr[int'(winner)*ADDR_W +: ADDR_W];
                        wdata_q   <= wdata[int'(winner)*DATA_W +: DATA_W];
                        sram_en   <= 1'b0;
                        sram_oe   <= wr[winner];
                        sram_we   <= 1'b1;
                        drive     <= wr[winner];
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    sram_we  <= ~op_wr;
                    wait_cnt <= WAIT_LOAD;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        if (!op_wr) begin
                            rdata <= sram_data;
                        end
                        sram_en        <= 1'b1;
                        sram_oe        <= 1'b1;
                        sram_we        <= 1'b1;
                        drive          <= 1'b0;
                        done[grant_id] <= 1'b1;
                        state          <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM models, a transaction-level memory and arbitration
// reference, and a second instance with three wait states.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int NCH  = 3;
    localparam int AW   = 18;
    localparam int DW   = 16;
    localparam int WAIT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    wr = '0;
    logic [NCH*AW-1:0] addr = '0;
    logic [NCH*DW-1:0] wdata = '0;
    logic [NCH-1:0]    done;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [1:0]        grant_id;
    logic [AW-1:0]     sram_addr;
    wire  [DW-1:0]     sram_data;
    logic              sram_en, sram_oe, sram_we;

    logic [1:0]        req_b = '0;
    logic [1:0]        wr_b = '0;
    logic [2*AW-1:0]   addr_b = '0;
    logic [2*DW-1:0]   wdata_b = '0;
    logic [1:0]        done_b;
    logic [DW-1:0]     rdata_b;
    logic              busy_b;
    logic [0:0]        grant_b;
    logic [AW-1:0]     sram_addr_b;
    wire  [DW-1:0]     sram_data_b;
    logic              sram_en_b, sram_oe_b, sram_we_b;

    sram_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .done(done), .rdata(rdata), .busy(busy), .grant_id(grant_id),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_en(sram_en), .sram_oe(sram_oe), .sram_we(sram_we)
    );

    sram_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst(rst), .req(req_b), .wr(wr_b), .addr(addr_b), .wdata(wdata_b),
        .done(done_b), .rdata(rdata_b), .busy(busy_b), .grant_id(grant_b),
        .sram_addr(sram_addr_b), .sram_data(sram_data_b),
        .sram_en(sram_en_b), .sram_oe(sram_oe_b), .sram_we(sram_we_b)
    );

    // Board SRAM for the main instance: unwritten locations read back a fixed address pattern.
    logic [DW-1:0] sram_mem [int];
    logic [DW-1:0] bus_out = '0;
    logic          pre_en = 1'b0;
    int            pre_a = 0;
    logic [DW-1:0] pre_d = '0;

    function automatic logic [DW-1:0] init_pattern(input int a);
        return DW'(a) ^ 16'hA5A5;
    endfunction

    always @(negedge clk) begin
        if (pre_en) begin
            sram_mem[pre_a] = pre_d;
        end else if (!sram_en && !sram_we) begin
            sram_mem[int'(sram_addr)] = sram_data;
        end
        bus_out = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)]
                                                   : init_pattern(int'(sram_addr));
    end

    assign sram_data   = (!sram_en && !sram_oe && sram_we) ? bus_out : 16'bz;
    assign sram_data_b = (!sram_en_b && !sram_oe_b && sram_we_b) ? {8'hC3, sram_addr_b[7:0]} : 16'bz;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_rdata = '0;

    function automatic logic [DW-1:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_pattern(a);
    endfunction

    function automatic logic [DW-1:0] peek(input int a);
        return sram_mem.exists(a) ? sram_mem[a] : init_pattern(a);
    endfunction

    task automatic preload(input int a, input logic [DW-1:0] d);
        @(posedge clk);
        pre_a  = a;
        pre_d  = d;
        pre_en = 1'b1;
        @(posedge clk);
        pre_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // One request on one channel; records what the bus and handshake did, checks are left to callers.
    task automatic do_txn(input int ch, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit drop_early,
                          output int lat, output int oe_c, output int we_c, output int drv_c,
                          output int busy_c, output int dcnt, output logic [DW-1:0] rd,
                          output logic [NCH-1:0] dv, output logic [1:0] gid);
        lat = -1; oe_c = 0; we_c = 0; drv_c = 0; busy_c = 0; dcnt = 0;
        rd = '0; dv = '0; gid = '0;
        @(negedge clk);
        req            = '0;
        req[ch]        = 1'b1;
        wr[ch]         = w;
        addr[ch*AW +: AW] = a;
        wdata[ch*DW +: DW] = d;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                wr    = NCH'($urandom());
                addr  = (NCH*AW)'({$urandom(), $urandom()});
                wdata = (NCH*DW)'({$urandom(), $urandom()});
                if (drop_early) req[ch] = 1'b0;
            end
            if (!sram_oe) oe_c++;
            if (!sram_we) we_c++;
            if (busy) busy_c++;
            if (w && !sram_en && sram_data === d) drv_c++;
            if (done !== '0) begin
                dcnt++;
                if (lat < 0) begin
                    lat = n;
                    rd  = rdata;
                    dv  = done;
                    gid = grant_id;
                end
                req[ch] = 1'b0;
            end
            if (lat >= 0 && n >= lat + 6) break;
        end
    endtask

    task automatic test_reset();
        logic [44:0] obs;
        rst = 1'b1;
        req = '0;
        req_b = '0;
        repeat (3) @(negedge clk);
        obs = {done, busy, grant_id, rdata, sram_addr, sram_en, sram_oe, sram_we};
        n_cmp++;
        if (obs !== {3'b000, 1'b0, 2'b00, 16'h0, 18'h0, 3'b111}) begin
            n_bad++;
            $display("FAIL reset_outputs_held: got %h want %h", obs, {3'b000, 1'b0, 2'b00, 16'h0, 18'h0, 3'b111});
        end
        n_cmp++;
        if ({done_b, busy_b, sram_en_b, sram_oe_b, sram_we_b} !== 6'b000111) begin
            n_bad++;
            $display("FAIL reset_w3: got %b want %b", {done_b, busy_b, sram_en_b, sram_oe_b, sram_we_b}, 6'b000111);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        obs = {done, busy, grant_id, rdata, sram_addr, sram_en, sram_oe, sram_we};
        n_cmp++;
        if (obs !== {3'b000, 1'b0, 2'b00, 16'h0, 18'h0, 3'b111}) begin
            n_bad++;
            $display("FAIL reset_idle_after_release: got %h want %h", obs, {3'b000, 1'b0, 2'b00, 16'h0, 18'h0, 3'b111});
        end
    endtask

    task automatic test_single_read();
        int lat, oe_c, we_c, drv_c, busy_c, dcnt;
        logic [DW-1:0] rd;
        logic [NCH-1:0] dv;
        logic [1:0] gid;
        preload(32'h10, 16'h1234);
        do_txn(1, 1'b0, 18'h00010, 16'h0, 1'b0, lat, oe_c, we_c, drv_c, busy_c, dcnt, rd, dv, gid);
        n_cmp++;
        if (lat !== WAIT + 2 || dv !== 3'b010 || gid !== 2'd1) begin
            n_bad++;
            $display("FAIL read_handshake: lat=%0d done=%b gid=%0d want lat=%0d done=010 gid=1", lat, dv, gid, WAIT + 2);
        end
        n_cmp++;
        if (rd !== 16'h1234) begin
            n_bad++;
            $display("FAIL read_data: got %h want 1234", rd);
        end
        n_cmp++;
        if (oe_c !== WAIT + 1 || we_c !== 0) begin
            n_bad++;
            $display("FAIL read_strobes: oe_low=%0d we_low=%0d want %0d and 0", oe_c, we_c, WAIT + 1);
        end
        exp_rdata = 16'h1234;
    endtask

    task automatic test_single_write();
        int lat, oe_c, we_c, drv_c, busy_c, dcnt;
        logic [DW-1:0] rd;
        logic [NCH-1:0] dv;
        logic [1:0] gid;
        do_txn(0, 1'b1, 18'h3FFFF, 16'hBEEF, 1'b0, lat, oe_c, we_c, drv_c, busy_c, dcnt, rd, dv, gid);
        n_cmp++;
        if (lat !== WAIT + 2 || dv !== 3'b001 || gid !== 2'd0) begin
            n_bad++;
            $display("FAIL write_handshake: lat=%0d done=%b gid=%0d want lat=%0d done=001 gid=0", lat, dv, gid, WAIT + 2);
        end
        n_cmp++;
        if (we_c !== WAIT || oe_c !== 0 || drv_c !== WAIT + 1) begin
            n_bad++;
            $display("FAIL write_strobes: we_low=%0d oe_low=%0d driven=%0d want %0d 0 %0d", we_c, oe_c, drv_c, WAIT, WAIT + 1);
        end
        n_cmp++;
        if (peek(32'h3FFFF) !== 16'hBEEF || rd !== exp_rdata) begin
            n_bad++;
            $display("FAIL write_store: mem=%h rdata=%h want BEEF and %h", peek(32'h3FFFF), rd, exp_rdata);
        end
        ref_mem[32'h3FFFF] = 16'hBEEF;
        do_txn(2, 1'b0, 18'h3FFFF, 16'h0, 1'b0, lat, oe_c, we_c, drv_c, busy_c, dcnt, rd, dv, gid);
        n_cmp++;
        if (rd !== 16'hBEEF || dv !== 3'b100) begin
            n_bad++;
            $display("FAIL read_after_write: rdata=%h done=%b want BEEF 100", rd, dv);
        end
        exp_rdata = 16'hBEEF;
    endtask

    task automatic test_random_traffic();
        int lat, oe_c, we_c, drv_c, busy_c, dcnt, ch, a;
        logic w;
        logic [DW-1:0] d, rd, expv;
        logic [NCH-1:0] dv;
        logic [1:0] gid;
        for (int it = 0; it < 24; it++) begin
            ch = $urandom_range(0, NCH - 1);
            w  = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 31);
            d  = DW'($urandom());
            expv = ref_read(a);
            do_txn(ch, w, AW'(a), d, 1'b0, lat, oe_c, we_c, drv_c, busy_c, dcnt, rd, dv, gid);
            n_cmp++;
            if (lat !== WAIT + 2 || dv !== NCH'(1 << ch) || gid !== 2'(ch) || busy_c !== WAIT + 2) begin
                n_bad++;
                $display("FAIL rand_handshake[%0d]: lat=%0d done=%b gid=%0d busy=%0d want %0d ch%0d busy=%0d",
                         it, lat, dv, gid, busy_c, WAIT + 2, ch, WAIT + 2);
            end
            n_cmp++;
            if (w) begin
                if (peek(a) !== d || rd !== exp_rdata) begin
                    n_bad++;
                    $display("FAIL rand_write[%0d]: mem=%h rdata=%h want %h and %h", it, peek(a), rd, d, exp_rdata);
                end
                ref_mem[a] = d;
            end else begin
                if (rd !== expv) begin
                    n_bad++;
                    $display("FAIL rand_read[%0d]: addr=%0h got %h want %h", it, a, rd, expv);
                end
                exp_rdata = expv;
            end
        end
    endtask

    task automatic test_drop_in_setup();
        int lat, oe_c, we_c, drv_c, busy_c, dcnt;
        logic [DW-1:0] rd;
        logic [NCH-1:0] dv;
        logic [1:0] gid;
        do_txn(1, 1'b0, 18'h3FFFF, 16'h0, 1'b1, lat, oe_c, we_c, drv_c, busy_c, dcnt, rd, dv, gid);
        n_cmp++;
        if (dcnt !== 1 || busy_c !== WAIT + 2 || lat !== WAIT + 2) begin
            n_bad++;
            $display("FAIL drop_in_setup: dones=%0d busy=%0d lat=%0d want 1 %0d %0d", dcnt, busy_c, lat, WAIT + 2, WAIT + 2);
        end
        n_cmp++;
        if (rd !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL drop_in_setup_data: got %h want BEEF", rd);
        end
        exp_rdata = 16'hBEEF;
    endtask

    task automatic test_contention();
        int rem[NCH];
        int expq[$];
        int last, pick, got, prev, dch;
        rem = '{3, 2, 2};
        last = NCH - 1;
        while (rem[0] + rem[1] + rem[2] > 0) begin
            pick = -1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            for (int k = 1; k <= NCH; k++) begin
                if (pick < 0 && rem[(last + k) % NCH] > 0) pick = (last + k) % NCH;
            end
`else
            for (int i = 0; i < NCH; i++) begin
                if (pick < 0 && rem[i] > 0) pick = i;
            end
`endif
            expq.push_back(pick);
            rem[pick]--;
            last = pick;
        end
        rem = '{3, 2, 2};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        wr  = '0;
        for (int i = 0; i < NCH; i++) addr[i*AW +: AW] = AW'(32'h40 + i);
        req = '1;
        got = 0;
        prev = -1;
        for (int n = 1; n <= 120 && got < expq.size(); n++) begin
            @(negedge clk);
            if (done !== '0) begin
                dch = -1;
                for (int i = 0; i < NCH; i++) if (done[i]) dch = i;
                n_cmp++;
                if (!$onehot(done) || dch !== expq[got] || rdata !== ref_read(32'h40 + dch)) begin
                    n_bad++;
                    $display("FAIL contention_order[%0d]: done=%b rdata=%h want ch%0d", got, done, rdata, expq[got]);
                end
                if (prev >= 0) begin
                    n_cmp++;
                    if (n - prev !== WAIT + 3) begin
                        n_bad++;
                        $display("FAIL contention_spacing[%0d]: got %0d cycles want %0d", got, n - prev, WAIT + 3);
                    end
                end
                prev = n;
                got++;
                if (dch >= 0) begin
                    rem[dch]--;
                    if (rem[dch] <= 0) req[dch] = 1'b0;
                end
            end
        end
        req = '0;
        n_cmp++;
        if (got !== expq.size()) begin
            n_bad++;
            $display("FAIL contention_count: got %0d dones want %0d", got, expq.size());
        end
        exp_rdata = ref_read(32'h40 + expq[expq.size() - 1]);
    endtask

    task automatic test_wait3();
        int n1, n2, oe_c;
        logic [DW-1:0] rd;
        n1 = -1; n2 = -1; oe_c = 0; rd = '0;
        @(negedge clk);
        wr_b = 2'b00;
        addr_b[AW-1:0] = 18'h00055;
        req_b = 2'b01;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n1 < 0 && !sram_oe_b) oe_c++;
            if (done_b[0]) begin
                if (n1 < 0) begin
                    n1 = n;
                    rd = rdata_b;
                end else if (n2 < 0) begin
                    n2 = n;
                    req_b = 2'b00;
                end
            end
            if (n2 >= 0 && n >= n2 + 2) break;
        end
        req_b = 2'b00;
        n_cmp++;
        if (n1 !== 5 || oe_c !== 4) begin
            n_bad++;
            $display("FAIL w3_latency: done_at=%0d oe_low=%0d want 5 4", n1, oe_c);
        end
        n_cmp++;
        if (rd !== 16'hC355) begin
            n_bad++;
            $display("FAIL w3_data: got %h want C355", rd);
        end
        n_cmp++;
        if (n2 - n1 !== 6 || n2 < 0) begin
            n_bad++;
            $display("FAIL w3_throughput: got %0d cycles want 6", n2 - n1);
        end
    endtask

    task automatic test_reset_mid_write();
        int dseen, lat;
        logic [NCH-1:0] dv;
        dseen = 0; lat = -1; dv = '0;
        @(negedge clk);
        wr = 3'b001;
        addr[AW-1:0] = 18'h00100;
        wdata[DW-1:0] = 16'h5A5A;
        req = 3'b001;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sram_we !== 1'b0 || sram_en !== 1'b0) begin
            n_bad++;
            $display("FAIL midwrite_in_access: en=%b we=%b want 0 0", sram_en, sram_we);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({sram_en, sram_oe, sram_we, busy, done} !== 7'b1110000) begin
            n_bad++;
            $display("FAIL midwrite_async_abort: got %b want 1110000", {sram_en, sram_oe, sram_we, busy, done});
        end
        wdata[DW-1:0] = 16'h6B6B;
        repeat (3) begin
            @(negedge clk);
            if (done !== '0) dseen++;
        end
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done !== '0 && lat < 0) begin
                lat = n;
                dv  = done;
                req = '0;
            end
            if (lat >= 0 && n >= lat + 2) break;
        end
        req = '0;
        n_cmp++;
        if (dseen !== 0 || lat !== WAIT + 2 || dv !== 3'b001) begin
            n_bad++;
            $display("FAIL midwrite_resume: dones_in_reset=%0d lat=%0d done=%b want 0 %0d 001", dseen, lat, dv, WAIT + 2);
        end
        n_cmp++;
        if (peek(32'h100) !== 16'h6B6B) begin
            n_bad++;
            $display("FAIL midwrite_store: got %h want 6B6B", peek(32'h100));
        end
        ref_mem[32'h100] = 16'h6B6B;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_random_traffic();
        test_drop_in_setup();
        test_contention();
        test_wait3();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
